// File: rtl/avl_istr_prefetch_if.sv
// Bundles the decode-side valid/ready handshake, the flush request and the
// instruction-side Avalon-MM read port. The prefetcher takes the master view.
interface avl_istr_prefetch_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        istr_valid;
    logic        istr_ready;
    logic [31:0] istr_data;
    logic [31:0] istr_pc;
    logic [31:0] avl_address;
    logic        avl_read;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;

    modport master (
        input  flush, flush_pc, istr_ready,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid,
        output istr_valid, istr_data, istr_pc,
        output avl_address, avl_read, avl_byteenable
    );

    modport slave (
        output flush, flush_pc, istr_ready,
        output avl_waitrequest, avl_readdata, avl_readdatavalid,
        input  istr_valid, istr_data, istr_pc,
        input  avl_address, avl_read, avl_byteenable
    );
endinterface

// File: rtl/avl_istr_prefetch.sv
// Instruction prefetch: pipelined sequential Avalon-MM reads buffered with their PC
// in a FIFO, handed to decode over valid/ready; flush redirects and drops stale data.
module avl_istr_prefetch #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rest,
    avl_istr_prefetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_cnt, fifo_cnt_next;
    logic [OW-1:0] outstanding, outstanding_next;
    logic [OW-1:0] discard_cnt, discard_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   resp_pc, resp_pc_next;
    logic [31:0]   addr_q, addr_next;
    logic          read_q, read_next;
    logic          stale_pend, stale_next;
    logic          accept, stall, resp, drop, push, pop, credit_ok;

    always_comb begin
        accept = read_q && !bus.avl_waitrequest;
        stall  = read_q && bus.avl_waitrequest;
        resp   = bus.avl_readdatavalid && (outstanding != '0);
        drop   = resp && (bus.flush || discard_cnt != '0);
        push   = resp && !drop;
        pop    = bus.istr_valid && bus.istr_ready && !bus.flush;

        outstanding_next = outstanding + OW'(accept) - OW'(resp);

        if (bus.flush) begin
            fifo_cnt_next = '0;
            discard_next  = outstanding_next;
            fetch_pc_next = bus.flush_pc;
            resp_pc_next  = bus.flush_pc;
            stale_next    = stall;
        end else begin
            fifo_cnt_next = fifo_cnt + CW'(push) - CW'(pop);
            discard_next  = discard_cnt - OW'(drop) + OW'(accept && stale_pend);
            fetch_pc_next = (accept && !stale_pend) ? fetch_pc + 32'd4 : fetch_pc;
            resp_pc_next  = push ? resp_pc + 32'd4 : resp_pc;
            stale_next    = accept ? 1'b0 : stale_pend;
        end

        // Reserve a FIFO slot for every live read plus the one about to be issued.
        credit_ok = (32'(fifo_cnt_next) + 32'(outstanding_next) - 32'(discard_next) + 32'd1)
                    <= FIFO_DEPTH;

        if (stall) begin
            read_next = 1'b1;
            addr_next = addr_q;
        end else begin
            read_next = credit_ok && (outstanding_next < OW'(MAX_OUTSTANDING));
            addr_next = fetch_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            read_q      <= 1'b0;
            addr_q      <= RESET_PC;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            stale_pend  <= 1'b0;
            fifo_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            read_q      <= read_next;
            addr_q      <= addr_next;
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            discard_cnt <= discard_next;
            stale_pend  <= stale_next;
            fifo_cnt    <= fifo_cnt_next;
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is data only; occupancy is tracked by the control registers above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.avl_readdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    assign bus.istr_valid     = (fifo_cnt != '0);
    assign bus.istr_data      = fifo_data[rd_ptr];
    assign bus.istr_pc        = fifo_pc[rd_ptr];
    assign bus.avl_read       = read_q;
    assign bus.avl_address    = addr_q;
    assign bus.avl_byteenable = 4'hF;

    assert property (@(posedge clk) disable iff (!rest)
                     bus.avl_readdatavalid |-> (outstanding != '0))
        else $error("readdatavalid with no read outstanding");
endmodule

// File: tb/tb_avl_istr_prefetch.sv
// Bench for avl_istr_prefetch: in-order Avalon slave model with random stall and
// latency, a scoreboarded decode consumer, and directed flush/reset scenarios.
module tb_avl_istr_prefetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rest;
    int   cyc = 0;
    avl_istr_prefetch_if bus ();

    avl_istr_prefetch #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(4), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rest(rest),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_addr_q[$];
    int          acc_cyc_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    bit          consume_en, ready_rand, wr_rand, stall_en;
    logic [31:0] stall_addr;
    int          lat_min, lat_max;
    int          first_valid_cyc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    // Avalon slave: acts at the falling edge so its outputs are settled for the next rising edge.
    task automatic slave_proc();
        bit          prev_stall = 1'b0;
        logic [31:0] prev_addr = '0;
        bit          wr;
        bus.avl_waitrequest   = 1'b0;
        bus.avl_readdata      = '0;
        bus.avl_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rest) begin
                pend_addr.delete();
                pend_due.delete();
                bus.avl_readdatavalid = 1'b0;
                bus.avl_waitrequest   = 1'b0;
                prev_stall            = 1'b0;
            end else begin
                if (prev_stall) begin
                    vectors++;
                    if (bus.avl_read !== 1'b1 || bus.avl_address !== prev_addr) begin
                        miscompares++;
                        $display("FAIL stall_hold: read=%b addr=%h, required read=1 addr=%h",
                                 bus.avl_read, bus.avl_address, prev_addr);
                    end
                end
                if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                    bus.avl_readdatavalid = 1'b1;
                    bus.avl_readdata      = memf(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.avl_readdatavalid = 1'b0;
                    bus.avl_readdata      = 32'hDEAD_BEEF;
                end
                wr = (stall_en && bus.avl_address == stall_addr) ||
                     (wr_rand && $urandom_range(1, 0) == 1);
                bus.avl_waitrequest = wr;
                if (bus.avl_read && !wr) begin
                    pend_addr.push_back(bus.avl_address);
                    pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                    acc_addr_q.push_back(bus.avl_address);
                    acc_cyc_q.push_back(cyc);
                end
                prev_stall = bus.avl_read && wr;
                prev_addr  = bus.avl_address;
            end
        end
    endtask

    // Decode-side consumer: pops only while expectations remain, checks PC and data.
    task automatic consumer_proc();
        logic [31:0] pc;
        bus.istr_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.istr_ready = consume_en && (exp_q.size() > 0) &&
                             (!ready_rand || $urandom_range(1, 0) == 1);
            #1;
            if (rest && bus.istr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rest && !bus.flush && bus.istr_valid && bus.istr_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_istr: pc=%h, required no instruction", bus.istr_pc);
                end else begin
                    pc = exp_q.pop_front();
                    if (bus.istr_pc !== pc || bus.istr_data !== memf(pc)) begin
                        miscompares++;
                        $display("FAIL istr: pc=%h data=%h, required pc=%h data=%h",
                                 bus.istr_pc, bus.istr_data, pc, memf(pc));
                    end
                end
            end
        end
    endtask

    task automatic set_defaults();
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        consume_en   = 1'b0;
        ready_rand   = 1'b0;
        wr_rand      = 1'b0;
        stall_en     = 1'b0;
        stall_addr   = '0;
        lat_min      = 1;
        lat_max      = 1;
        exp_q.delete();
        acc_addr_q.delete();
        acc_cyc_q.delete();
        first_valid_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rest = 1'b0;
        set_defaults();
        repeat (3) @(negedge clk);
        rest = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d instructions left, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_accepts(input int count, input int budget, input string name);
        int n = 0;
        while (acc_addr_q.size() < count && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        vectors++;
        if (acc_addr_q.size() != count) begin
            miscompares++;
            $display("FAIL %s_accepts: got %0d, required %0d", name, acc_addr_q.size(), count);
        end
    endtask

    task automatic test_reset();
        set_defaults();
        rest = 1'b1;
        #3 rest = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.avl_read !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_read: got %b, required 0", bus.avl_read);
        end
        vectors++;
        if (bus.avl_address !== RST_PC) begin
            miscompares++;
            $display("FAIL rst_addr: got %h, required %h", bus.avl_address, RST_PC);
        end
        vectors++;
        if (bus.istr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_valid: got %b, required 0", bus.istr_valid);
        end
        vectors++;
        if (bus.avl_byteenable !== 4'hF) begin
            miscompares++;
            $display("FAIL byteenable: got %h, required f", bus.avl_byteenable);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
        consume_en = 1'b1;
        wait_drain(200, "seq");
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (acc_addr_q.size() <= i) begin
                miscompares++;
                $display("FAIL seq_addr[%0d]: missing, required %h", i, 32'(i * 4));
            end else if (acc_addr_q[i] !== 32'(i * 4) || acc_cyc_q[i] != acc_cyc_q[0] + i) begin
                miscompares++;
                $display("FAIL seq_addr[%0d]: addr=%h cycle=+%0d, required addr=%h cycle=+%0d",
                         i, acc_addr_q[i], acc_cyc_q[i] - acc_cyc_q[0], 32'(i * 4), i);
            end
        end
        vectors++;
        if (acc_cyc_q.size() == 0 || first_valid_cyc != acc_cyc_q[0] + 2) begin
            miscompares++;
            $display("FAIL seq_latency: first valid cycle %0d, required first accept + 2",
                     first_valid_cyc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (20) @(negedge clk);
        #2;
        vectors++;
        if (acc_addr_q.size() != 4 || bus.avl_read !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stop: accepts=%0d read=%b, required accepts=4 read=0",
                     acc_addr_q.size(), bus.avl_read);
        end
        vectors++;
        if (bus.istr_valid !== 1'b1 || bus.istr_pc !== 32'h0 || bus.istr_data !== memf(32'h0)) begin
            miscompares++;
            $display("FAIL bp_head: valid=%b pc=%h data=%h, required valid=1 pc=0 data=%h",
                     bus.istr_valid, bus.istr_pc, bus.istr_data, memf(32'h0));
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        consume_en = 1'b1;
        wait_drain(200, "bp");
        vectors++;
        if (acc_addr_q.size() < 5 || acc_addr_q[4] !== 32'h10) begin
            miscompares++;
            $display("FAIL bp_resume: fifth accept %h, required 00000010",
                     acc_addr_q.size() < 5 ? 32'hFFFF_FFFF : acc_addr_q[4]);
        end
    endtask

    task automatic test_random_wait();
        do_reset();
        wr_rand    = 1'b1;
        ready_rand = 1'b1;
        lat_min    = 1;
        lat_max    = 3;
        for (int i = 0; i < 24; i++) exp_q.push_back(32'(i * 4));
        consume_en = 1'b1;
        wait_drain(3000, "rnd");
        for (int i = 0; i < 24; i += 4) begin
            vectors++;
            if (acc_addr_q.size() <= i || acc_addr_q[i] !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL rnd_addr[%0d]: got %h, required %h", i,
                         acc_addr_q.size() <= i ? 32'hFFFF_FFFF : acc_addr_q[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_flush_outstanding();
        int t;
        do_reset();
        lat_min    = 5;
        lat_max    = 5;
        consume_en = 1'b1;
        wait_accepts(2, 50, "fo");
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h100;
        t = cyc;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        #2;
        vectors++;
        if (acc_addr_q.size() != 3) begin
            miscompares++;
            $display("FAIL fo_outstanding: accepts at flush %0d, required 3", acc_addr_q.size());
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #2;
        vectors++;
        if (acc_addr_q.size() < 4 || acc_addr_q[3] !== 32'h100 || acc_cyc_q[3] != t + 1) begin
            miscompares++;
            $display("FAIL fo_issue: read=%b addr=%h at flush+1, required accept of 00000100",
                     bus.avl_read, bus.avl_address);
        end
        wait_drain(300, "fo");
    endtask

    task automatic test_flush_stalled();
        int n;
        bit ok = 1'b0;
        do_reset();
        stall_en   = 1'b1;
        stall_addr = 32'h20;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        consume_en = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #2;
            ok = (exp_q.size() == 0) && bus.avl_read && (bus.avl_address == 32'h20);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL fs_setup: read=%b addr=%h, required stalled read of 00000020",
                     bus.avl_read, bus.avl_address);
        end
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h200;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        @(negedge clk);
        bus.flush = 1'b0;
        #2;
        vectors++;
        if (bus.avl_read !== 1'b1 || bus.avl_address !== 32'h20) begin
            miscompares++;
            $display("FAIL fs_hold: read=%b addr=%h, required read=1 addr=00000020",
                     bus.avl_read, bus.avl_address);
        end
        repeat (2) @(negedge clk);
        #2;
        n = acc_addr_q.size();
        stall_en = 1'b0;
        wait_drain(200, "fs");
        vectors++;
        if (acc_addr_q.size() < n + 2 || acc_addr_q[n] !== 32'h20 ||
            acc_addr_q[n+1] !== 32'h200 || acc_cyc_q[n+1] != acc_cyc_q[n] + 1) begin
            miscompares++;
            $display("FAIL fs_order: accepts after release %0d, required 00000020 then 00000200 back to back",
                     acc_addr_q.size() - n);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        lat_min    = 4;
        lat_max    = 4;
        consume_en = 1'b1;
        wait_accepts(2, 50, "rm");
        rest = 1'b0;
        #1;
        vectors++;
        if (bus.avl_read !== 1'b0 || bus.avl_address !== RST_PC || bus.istr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_reset: read=%b addr=%h valid=%b, required 0 %h 0",
                     bus.avl_read, bus.avl_address, bus.istr_valid, RST_PC);
        end
        exp_q.delete();
        acc_addr_q.delete();
        acc_cyc_q.delete();
        repeat (2) @(negedge clk);
        rest = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(RST_PC + 32'(i * 4));
        wait_drain(300, "rm");
        vectors++;
        if (acc_addr_q.size() < 2 || acc_addr_q[0] !== RST_PC || acc_addr_q[1] !== RST_PC + 32'd4) begin
            miscompares++;
            $display("FAIL rm_restart: first accepts %0d, required %h then %h",
                     acc_addr_q.size(), RST_PC, RST_PC + 32'd4);
        end
    endtask

    initial begin
        set_defaults();
        fork
            slave_proc();
            consumer_proc();
        join_none
        test_reset();
        test_sequential();
        test_backpressure();
        test_random_wait();
        test_flush_outstanding();
        test_flush_stalled();
        test_reset_midburst();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
